pair_serializer: RTL and testbench

Converts the two-word parallel butterfly bus (operands `a`, `b`, each a 32-bit complex sample) back into a single word-serial stream. It is the consuming end of the pair bus between radix stages and the output/memory-write path. It buffers up to DEPTH pairs behind a valid/ready handshake and emits `a` then `b` of each pair, one word per accepted output cycle. It also checks the frame length against the upstream `in_last` marker.

---
 rtl/pair_serializer_if.sv | 25 ++
 rtl/pair_serializer.sv | 138 +++++++++++++
 tb/tb_pair_serializer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pair_serializer_if.sv
// Pair-bus to word-serial handshake bundle: upstream pair side plus serial output side.
// The slave modport is the serializer; master is whatever drives pairs in and drains words.
interface pair_serializer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sel;
    logic        out_last;
    logic        frame_err;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_last, frame_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_last, frame_err
    );
endinterface

// File: rtl/pair_serializer.sv
// Buffers up to DEPTH {a, b, last} pairs and replays them as a, b words on a serial
// valid/ready stream; also flags frames whose length disagrees with in_last.
module pair_serializer #(
    parameter int DEPTH       = 2,
    parameter int FRAME_PAIRS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    pair_serializer_if.slave    bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PC_W  = (FRAME_PAIRS > 1) ? $clog2(FRAME_PAIRS) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(FRAME_PAIRS - 1);

    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } phase_t;

    phase_t            r_phase;
    phase_t            w_phase_nxt;

    logic [31:0]       r_mem_a    [DEPTH];
    logic [31:0]       r_mem_b    [DEPTH];
    logic              r_mem_last [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [PC_W-1:0]   r_pair_cnt;
    logic              r_frame_err;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_push;
    logic              w_out_hs;
    logic              w_pop;
    logic              w_pc_at_end;

    // in_ready comes from occupancy alone, so a pop never lets a push into a full buffer.
    always_comb begin
        w_in_ready  = (r_count != CNT_FULL);
        w_out_valid = (r_count != '0);
        w_push      = bus.in_valid & w_in_ready;
        w_out_hs    = w_out_valid & bus.out_ready;
        w_pc_at_end = (r_pair_cnt == PC_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= PH_A;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        w_pop       = 1'b0;
        case (r_phase)
            PH_A: begin
                if (w_out_hs) begin
                    w_phase_nxt = PH_B;
                end
            end
            PH_B: begin
                if (w_out_hs) begin
                    w_phase_nxt = PH_A;
                    w_pop       = 1'b1;
                end
            end
            default: begin
                w_phase_nxt = PH_A;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem_a[i]    <= '0;
                r_mem_b[i]    <= '0;
                r_mem_last[i] <= 1'b0;
            end
        end else if (w_push) begin
            r_mem_a[r_wr_ptr]    <= bus.in_a;
            r_mem_b[r_wr_ptr]    <= bus.in_b;
            r_mem_last[r_wr_ptr] <= bus.in_last;
        end
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pair_cnt  <= '0;
            r_frame_err <= 1'b0;
        end else if (w_push) begin
            if (bus.in_last || w_pc_at_end) begin
                r_pair_cnt <= '0;
            end else begin
                r_pair_cnt <= r_pair_cnt + PC_W'(1);
            end
            if (bus.in_last != w_pc_at_end) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.in_ready  = w_in_ready;
        bus.out_valid = w_out_valid;
        bus.out_data  = (r_phase == PH_B) ? r_mem_b[r_rd_ptr] : r_mem_a[r_rd_ptr];
        bus.out_sel   = (r_phase == PH_B);
        bus.out_last  = (r_phase == PH_B) & r_mem_last[r_rd_ptr];
        bus.frame_err = r_frame_err;
    end
endmodule

// File: tb/tb_pair_serializer.sv
// Directed bench for pair_serializer: a DEPTH=2/FRAME_PAIRS=3 instance for most steps
// and a FRAME_PAIRS=1 instance for the single-pair frame.
module tb_pair_serializer;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pair_serializer_if b_if ();
    pair_serializer_if s_if ();

    pair_serializer #(.DEPTH(2), .FRAME_PAIRS(3)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    pair_serializer #(.DEPTH(2), .FRAME_PAIRS(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] d,
                           input logic sel, input logic last);
        chk({tag, "_valid"}, b_if.out_valid, v);
        chk({tag, "_data"},  b_if.out_data,  d);
        chk({tag, "_sel"},   b_if.out_sel,   sel);
        chk({tag, "_last"},  b_if.out_last,  last);
    endtask

    task automatic push_wait(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic last);
        logic ok;
        ok = 1'b0;
        b_if.in_valid = 1'b1;
        b_if.in_a     = a;
        b_if.in_b     = b;
        b_if.in_last  = last;
        for (int i = 0; i < 20; i++) begin
            if (b_if.in_ready) begin
                step();
                ok = 1'b1;
                break;
            end
            step();
        end
        b_if.in_valid = 1'b0;
        chk({tag, "_push_done"}, ok, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            p;
        logic          exp_rdy;
        int            k;
        logic [31:0]   exp_d;

        rst_n         = 1'b0;
        b_if.in_valid = 1'b0;
        b_if.in_a     = '0;
        b_if.in_b     = '0;
        b_if.in_last  = 1'b0;
        b_if.out_ready = 1'b0;
        s_if.in_valid = 1'b0;
        s_if.in_a     = '0;
        s_if.in_b     = '0;
        s_if.in_last  = 1'b0;
        s_if.out_ready = 1'b0;
        step();
        step();

        // reset state
        chk("rst_in_ready", b_if.in_ready, 1'b1);
        chk_out("rst", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rst_frame_err", b_if.frame_err, 1'b0);
        rst_n = 1'b1;
        step();

        // single pair, FRAME_PAIRS=1
        s_if.in_valid  = 1'b1;
        s_if.in_a      = 32'h0001_0002;
        s_if.in_b      = 32'h0003_0004;
        s_if.in_last   = 1'b1;
        s_if.out_ready = 1'b1;
        chk("sp_in_ready", s_if.in_ready, 1'b1);
        chk("sp_empty_valid", s_if.out_valid, 1'b0);
        step();
        s_if.in_valid = 1'b0;
        chk("sp_a_valid", s_if.out_valid, 1'b1);
        chk("sp_a_data", s_if.out_data, 32'h0001_0002);
        chk("sp_a_sel", s_if.out_sel, 1'b0);
        chk("sp_a_last", s_if.out_last, 1'b0);
        step();
        chk("sp_b_data", s_if.out_data, 32'h0003_0004);
        chk("sp_b_sel", s_if.out_sel, 1'b1);
        chk("sp_b_last", s_if.out_last, 1'b1);
        step();
        chk("sp_drained", s_if.out_valid, 1'b0);
        chk("sp_frame_err", s_if.frame_err, 1'b0);

        // back-pressure and fill
        b_if.out_ready = 1'b0;
        b_if.in_valid  = 1'b1;
        b_if.in_a = 32'h1111_0000; b_if.in_b = 32'h1111_0001; b_if.in_last = 1'b0;
        chk("bp_p0_ready", b_if.in_ready, 1'b1);
        step();
        b_if.in_a = 32'h2222_0000; b_if.in_b = 32'h2222_0001; b_if.in_last = 1'b0;
        chk("bp_p1_ready", b_if.in_ready, 1'b1);
        chk_out("bp_hold1", 1'b1, 32'h1111_0000, 1'b0, 1'b0);
        step();
        b_if.in_a = 32'h3333_0000; b_if.in_b = 32'h3333_0001; b_if.in_last = 1'b1;
        chk("bp_full_ready", b_if.in_ready, 1'b0);
        chk_out("bp_hold2", 1'b1, 32'h1111_0000, 1'b0, 1'b0);
        step();
        chk("bp_still_full", b_if.in_ready, 1'b0);
        chk_out("bp_hold3", 1'b1, 32'h1111_0000, 1'b0, 1'b0);
        b_if.out_ready = 1'b1;
        step();
        chk_out("bp_p0b", 1'b1, 32'h1111_0001, 1'b1, 1'b0);
        chk("bp_p0b_ready", b_if.in_ready, 1'b0);
        step();
        chk_out("bp_p1a", 1'b1, 32'h2222_0000, 1'b0, 1'b0);
        chk("bp_ready_rise", b_if.in_ready, 1'b1);
        step();
        b_if.in_valid = 1'b0;
        chk_out("bp_p1b", 1'b1, 32'h2222_0001, 1'b1, 1'b0);
        step();
        chk_out("bp_p2a", 1'b1, 32'h3333_0000, 1'b0, 1'b0);
        step();
        chk_out("bp_p2b", 1'b1, 32'h3333_0001, 1'b1, 1'b1);
        step();
        chk("bp_drained", b_if.out_valid, 1'b0);

        // streaming: 12 pairs, in_last on every third pair
        p = 0;
        for (int c = 0; c <= 24; c++) begin
            if (p < 12) begin
                b_if.in_valid = 1'b1;
                b_if.in_a     = 32'hA000_0000 | 32'(p);
                b_if.in_b     = 32'hB000_0000 | 32'(p);
                b_if.in_last  = ((p % 3) == 2);
            end else begin
                b_if.in_valid = 1'b0;
            end
            exp_rdy = (c == 0) || ((c % 2) == 1);
            if (c <= 22) begin
                chk($sformatf("st_ready_c%0d", c), b_if.in_ready, exp_rdy);
            end
            if (c >= 1) begin
                k     = c - 1;
                exp_d = ((k % 2) == 0) ? (32'hA000_0000 | 32'(k / 2)) : (32'hB000_0000 | 32'(k / 2));
                chk_out($sformatf("st_w%0d", k), 1'b1, exp_d, ((k % 2) == 1),
                        ((k % 2) == 1) && (((k / 2) % 3) == 2));
            end
            if (p < 12 && exp_rdy) begin
                p++;
            end
            step();
        end
        b_if.in_valid = 1'b0;
        chk("st_drained", b_if.out_valid, 1'b0);
        chk("st_frame_err", b_if.frame_err, 1'b0);

        // short frame: in_last on the second pair
        push_wait("fe_q0", 32'hC000_0000, 32'hC000_0001, 1'b0);
        chk("fe_before", b_if.frame_err, 1'b0);
        push_wait("fe_q1", 32'hD000_0000, 32'hD000_0001, 1'b1);
        chk("fe_set", b_if.frame_err, 1'b1);
        chk_out("fe_q0b", 1'b1, 32'hC000_0001, 1'b1, 1'b0);
        step();
        chk_out("fe_q1a", 1'b1, 32'hD000_0000, 1'b0, 1'b0);
        step();
        chk_out("fe_q1b", 1'b1, 32'hD000_0001, 1'b1, 1'b1);
        step();
        chk("fe_drained", b_if.out_valid, 1'b0);
        step();
        step();
        step();
        chk("fe_sticky", b_if.frame_err, 1'b1);

        // reset mid-stream with phase=1 and two pairs buffered
        b_if.out_ready = 1'b0;
        push_wait("rs_r0", 32'hE000_0000, 32'hE000_0001, 1'b0);
        push_wait("rs_r1", 32'hE100_0000, 32'hE100_0001, 1'b0);
        b_if.out_ready = 1'b1;
        chk("rs_r0a", b_if.out_data, 32'hE000_0000);
        step();
        b_if.out_ready = 1'b0;
        chk_out("rs_r0b", 1'b1, 32'hE000_0001, 1'b1, 1'b0);
        chk("rs_full", b_if.in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_out("rs_async", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("rs_in_ready", b_if.in_ready, 1'b1);
        chk("rs_frame_err", b_if.frame_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rs_after_empty", b_if.out_valid, 1'b0);
        push_wait("rs_n", 32'hF000_0000, 32'hF000_0001, 1'b0);
        chk_out("rs_na", 1'b1, 32'hF000_0000, 1'b0, 1'b0);
        b_if.out_ready = 1'b1;
        step();

        // simultaneous push and pop with count=1, phase=1
        b_if.in_valid = 1'b1;
        b_if.in_a = 32'h5A00_0000; b_if.in_b = 32'h5A00_0001; b_if.in_last = 1'b0;
        chk("pp_ready", b_if.in_ready, 1'b1);
        chk_out("pp_nb", 1'b1, 32'hF000_0001, 1'b1, 1'b0);
        step();
        b_if.in_valid = 1'b0;
        chk("pp_count_same", b_if.in_ready, 1'b1);
        chk_out("pp_ma", 1'b1, 32'h5A00_0000, 1'b0, 1'b0);
        step();
        chk_out("pp_mb", 1'b1, 32'h5A00_0001, 1'b1, 1'b0);
        step();
        chk("pp_drained", b_if.out_valid, 1'b0);
        chk("pp_frame_err", b_if.frame_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
